// File: rtl/ef_dac_seq_pkg.sv
// Shared state encoding and bus widths for the DAC sample sequencer.
package ef_dac_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESET  = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } dac_seq_state_t;

   localparam int DAC_BITS = 10;
   localparam int DIV_BITS = 16;

endpackage

// File: rtl/ef_dac_seq_fifo.sv
// Synchronous sample FIFO with flush; level saturates at DEPTH because pushes are refused when full.
module ef_dac_seq_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   input  logic                       i_clr,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
   localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_do_push;
   logic             w_do_pop;

   // A flush overrides both push and pop in the same cycle.
   assign o_full    = (r_level == LVL_FULL);
   assign o_empty   = (r_level == LVL_ZERO);
   assign w_do_push = i_push & ~o_full & ~i_clr;
   assign w_do_pop  = i_pop & ~o_empty & ~i_clr;
   assign o_head    = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_level  <= LVL_ZERO;
      end else if (i_clr) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_level  <= LVL_ZERO;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/ef_dac_sample_sequencer.sv
// DAC front end: power-up sequencing (RST pulse, EN settle) then paced FIFO playout onto SELD.
// Optional threshold interrupt enabled by defining EF_DAC_SEQ_THRESH_IRQ_EN.
module ef_dac_sample_sequencer
   import ef_dac_seq_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int RST_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [DIV_BITS-1:0]        clk_div,
   input  logic [DAC_BITS-1:0]        sample_data,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic                       fifo_clr,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                       underrun,
   input  logic                       underrun_clr,
   output logic                       running,
   output logic                       dac_en,
   output logic                       dac_rst,
   output logic [DAC_BITS-1:0]        dac_seld
`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
   ,
   input  logic [$clog2(DEPTH+1)-1:0] fifo_thresh,
   output logic                       irq
`endif
);

   localparam int LVL_W  = $clog2(DEPTH+1);
   localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX+1);
   localparam logic [PH_W-1:0]     PH_ZERO     = {PH_W{1'b0}};
   localparam logic [PH_W-1:0]     PH_ONE      = PH_W'(1'b1);
   localparam logic [PH_W-1:0]     RST_LAST    = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0]     SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [DIV_BITS-1:0] CNT_ZERO    = {DIV_BITS{1'b0}};
   localparam logic [DIV_BITS-1:0] CNT_ONE     = DIV_BITS'(1'b1);
   localparam logic [DAC_BITS-1:0] SELD_ZERO   = {DAC_BITS{1'b0}};

   dac_seq_state_t      r_state;
   dac_seq_state_t      w_state_nxt;
   logic [PH_W-1:0]     r_phase;
   logic [PH_W-1:0]     w_phase_nxt;
   logic [DIV_BITS-1:0] r_cnt;
   logic                w_tick;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [DAC_BITS-1:0] w_head;
   logic [LVL_W-1:0]    w_level;
   logic                r_underrun;
   logic                r_running;
   logic                r_dac_en;
   logic                r_dac_rst;
   logic [DAC_BITS-1:0] r_dac_seld;

   // Ticks are gated by en so a tick can never pop on the edge that drops back to IDLE.
   assign w_tick       = (r_state == RUN) & en & (r_cnt >= clk_div);
   assign sample_ready = ~w_full & ~fifo_clr;
   assign w_push       = sample_valid & sample_ready;
   assign w_pop        = w_tick & ~w_empty & ~fifo_clr;

   ef_dac_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DAC_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (sample_data),
      .i_pop   (w_pop),
      .i_clr   (fifo_clr),
      .o_head  (w_head),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State and phase registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_phase <= PH_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   // Power-up sequencing; the phase counter is shared by RESET and SETTLE.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      if (!en) begin
         w_state_nxt = IDLE;
         w_phase_nxt = PH_ZERO;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = RESET;
               w_phase_nxt = PH_ZERO;
            end
            RESET: begin
               if (r_phase == RST_LAST) begin
                  w_state_nxt = SETTLE;
                  w_phase_nxt = PH_ZERO;
               end else begin
                  w_state_nxt = RESET;
                  w_phase_nxt = r_phase + PH_ONE;
               end
            end
            SETTLE: begin
               if (r_phase == SETTLE_LAST) begin
                  w_state_nxt = RUN;
                  w_phase_nxt = PH_ZERO;
               end else begin
                  w_state_nxt = SETTLE;
                  w_phase_nxt = r_phase + PH_ONE;
               end
            end
            RUN: begin
               w_state_nxt = RUN;
               w_phase_nxt = PH_ZERO;
            end
            default: begin
               w_state_nxt = IDLE;
               w_phase_nxt = PH_ZERO;
            end
         endcase
      end
   end

   // Sample-rate prescaler; >= keeps a lowered clk_div from wrapping through 2^16.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= CNT_ZERO;
      end else if ((r_state != RUN) || !en) begin
         r_cnt <= CNT_ZERO;
      end else if (w_tick) begin
         r_cnt <= CNT_ZERO;
      end else begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // DAC pin registers follow the upcoming state so they change on the same edge as the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dac_rst  <= 1'b1;
         r_dac_en   <= 1'b0;
         r_running  <= 1'b0;
         r_dac_seld <= SELD_ZERO;
      end else begin
         r_dac_rst <= (w_state_nxt == IDLE) | (w_state_nxt == RESET);
         r_dac_en  <= (w_state_nxt == SETTLE) | (w_state_nxt == RUN);
         r_running <= (w_state_nxt == RUN);
         if (w_state_nxt != RUN) begin
            r_dac_seld <= SELD_ZERO;
         end else if (w_pop) begin
            r_dac_seld <= w_head;
         end else begin
            r_dac_seld <= r_dac_seld;
         end
      end
   end

   // Sticky underrun; a flushed FIFO counts as empty and a new event beats the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underrun <= 1'b0;
      end else if (w_tick & (w_empty | fifo_clr)) begin
         r_underrun <= 1'b1;
      end else if (underrun_clr) begin
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= r_underrun;
      end
   end

`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
   logic r_irq;

   // Low-water interrupt, level-sensitive, re-evaluated every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_running & (w_level <= fifo_thresh);
      end
   end

   assign irq = r_irq;
`endif

   assign fifo_level = w_level;
   assign underrun   = r_underrun;
   assign running    = r_running;
   assign dac_en     = r_dac_en;
   assign dac_rst    = r_dac_rst;
   assign dac_seld   = r_dac_seld;

endmodule

// File: tb/tb_ef_dac_sample_sequencer.sv
// Self-checking bench for ef_dac_sample_sequencer: vector table for FIFO fill plus a cycle model with a sample scoreboard.
module tb_ef_dac_sample_sequencer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] clk_div;
   logic [9:0]  sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic        fifo_clr;
   logic [4:0]  fifo_level;
   logic        underrun;
   logic        underrun_clr;
   logic        running;
   logic        dac_en;
   logic        dac_rst;
   logic [9:0]  dac_seld;
`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
   logic [4:0]  fifo_thresh;
   logic        irq;
`endif

   ef_dac_sample_sequencer #(
      .DEPTH         (DEPTH),
      .RST_CYCLES    (4),
      .SETTLE_CYCLES (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .clk_div      (clk_div),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .fifo_clr     (fifo_clr),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .running      (running),
      .dac_en       (dac_en),
      .dac_rst      (dac_rst),
      .dac_seld     (dac_seld)
`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
      ,
      .fifo_thresh  (fifo_thresh),
      .irq          (irq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [9:0] data;
      logic       clr;
      logic       exp_ready;
      logic [4:0] exp_level;
   } vec_t;

   vec_t       vecs [21];
   int         n_vec = 0;
   int         n_err = 0;
   logic [9:0] sb_q [$];
   logic [9:0] m_seld;
   logic       m_under;
   logic       m_run;
   logic [15:0] m_cnt;
   logic       m_irq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus with the reference model predicting the post-edge outputs.
   task automatic cyc(input logic v, input logic [9:0] d, input logic clr, input logic uclr);
      logic tick;
      logic empty;
      logic full;
      logic acc;
      sample_valid = v;
      sample_data  = d;
      fifo_clr     = clr;
      underrun_clr = uclr;
      empty = (sb_q.size() == 0);
      full  = (sb_q.size() == DEPTH);
      acc   = v & !full & !clr;
      tick  = m_run & en & (m_cnt >= clk_div);
`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
      m_irq = m_run & (sb_q.size() <= int'(fifo_thresh));
`endif
      #1;
      check("ready", 32'(sample_ready), 32'(!full & !clr));
      if (m_run & en) m_cnt = tick ? 16'd0 : m_cnt + 16'd1;
      else m_cnt = 16'd0;
      if (tick & (empty | clr)) m_under = 1'b1;
      else if (uclr) m_under = 1'b0;
      if (clr) sb_q.delete();
      else if (tick & !empty) m_seld = sb_q.pop_front();
      if (acc) sb_q.push_back(d);
      if (!en) begin
         m_seld = 10'd0;
         m_run  = 1'b0;
      end
      step();
      sample_valid = 1'b0;
      fifo_clr     = 1'b0;
      underrun_clr = 1'b0;
      check("seld", 32'(dac_seld), 32'(m_seld));
      check("underrun", 32'(underrun), 32'(m_under));
      check("level", 32'(fifo_level), 32'(sb_q.size()));
      check("running", 32'(running), 32'(m_run));
`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
      check("irq", 32'(irq), 32'(m_irq));
`endif
   endtask

   task automatic power_up();
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("pu_rst_hi", 32'(dac_rst), 32'd1);
         check("pu_en_lo", 32'(dac_en), 32'd0);
      end
      for (int k = 0; k < 32; k++) begin
         step();
         check("pu_settle_en", 32'(dac_en), 32'd1);
         check("pu_settle_rst", 32'(dac_rst), 32'd0);
         check("pu_settle_run", 32'(running), 32'd0);
      end
      step();
      check("pu_running", 32'(running), 32'd1);
      check("pu_seld", 32'(dac_seld), 32'd0);
      m_run = 1'b1;
      m_cnt = 16'd0;
   endtask

   task automatic wait_tick_next();
      for (int g = 0; g < 64 && !(m_cnt >= clk_div); g++) cyc(1'b0, 10'd0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 17; i++) begin
         vecs[i].valid     = 1'b1;
         vecs[i].data      = 10'(i * 37 + 5);
         vecs[i].clr       = 1'b0;
         vecs[i].exp_ready = (i < 16);
         vecs[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
      end
      vecs[17] = '{1'b1, 10'h2AA, 1'b1, 1'b0, 5'd0};
      vecs[18] = '{1'b1, 10'h000, 1'b0, 1'b1, 5'd1};
      vecs[19] = '{1'b1, 10'h3FF, 1'b0, 1'b1, 5'd2};
      vecs[20] = '{1'b1, 10'h155, 1'b0, 1'b1, 5'd3};

      rst = 1'b1; en = 1'b0; clk_div = 16'd3; sample_data = 10'd0;
      sample_valid = 1'b0; fifo_clr = 1'b0; underrun_clr = 1'b0;
`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
      fifo_thresh = 5'd2;
`endif
      m_seld = 10'd0; m_under = 1'b0; m_run = 1'b0; m_cnt = 16'd0; m_irq = 1'b0;
      repeat (3) step();
      check("rst_dac_rst", 32'(dac_rst), 32'd1);
      check("rst_dac_en", 32'(dac_en), 32'd0);
      check("rst_seld", 32'(dac_seld), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_ready", 32'(sample_ready), 32'd1);
      rst = 1'b0;
      step();

      // FIFO fill / overflow / flush in IDLE from the vector table.
      for (int i = 0; i < 21; i++) begin
         sample_valid = vecs[i].valid;
         sample_data  = vecs[i].data;
         fifo_clr     = vecs[i].clr;
         #1;
         check($sformatf("vec%0d_ready", i), 32'(sample_ready), 32'(vecs[i].exp_ready));
         if (vecs[i].clr) sb_q.delete();
         else if (vecs[i].valid & vecs[i].exp_ready) sb_q.push_back(vecs[i].data);
         step();
         sample_valid = 1'b0;
         fifo_clr     = 1'b0;
         check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      end

      // Power-up then paced playout of 0x000, 0x3FF, 0x155 at clk_div=3.
      power_up();
      for (int k = 0; k < 16; k++) cyc(1'b0, 10'd0, 1'b0, 1'b0);
      check("stream_last", 32'(dac_seld), 32'h155);
      check("stream_underrun", 32'(underrun), 32'd1);

      // Clear racing a new underrun: set wins; a clear alone drops it.
      wait_tick_next();
      cyc(1'b0, 10'd0, 1'b0, 1'b1);
      check("set_wins", 32'(underrun), 32'd1);
      cyc(1'b0, 10'd0, 1'b0, 1'b1);
      check("clr_alone", 32'(underrun), 32'd0);

      // Flush with push and tick together.
      cyc(1'b1, 10'h0AB, 1'b0, 1'b0);
      wait_tick_next();
      cyc(1'b1, 10'h0EF, 1'b1, 1'b0);
      check("flush_level", 32'(fifo_level), 32'd0);
      check("flush_underrun", 32'(underrun), 32'd1);
      check("flush_seld", 32'(dac_seld), 32'h155);

      // clk_div=0: tick every cycle, push and pop together.
      clk_div = 16'd0;
      cyc(1'b1, 10'h011, 1'b0, 1'b0);
      cyc(1'b1, 10'h022, 1'b0, 1'b0);
      cyc(1'b1, 10'h033, 1'b0, 1'b0);
      cyc(1'b0, 10'd0, 1'b0, 1'b0);
      cyc(1'b0, 10'd0, 1'b0, 1'b0);
      check("div0_seld", 32'(dac_seld), 32'h033);

      // Drop en mid-run: SELD cleared, FIFO kept.
      clk_div = 16'd100;
      cyc(1'b1, 10'h101, 1'b0, 1'b0);
      cyc(1'b1, 10'h202, 1'b0, 1'b0);
      cyc(1'b1, 10'h303, 1'b0, 1'b0);
      en = 1'b0;
      cyc(1'b0, 10'd0, 1'b0, 1'b0);
      check("en0_seld", 32'(dac_seld), 32'd0);
      check("en0_level", 32'(fifo_level), 32'd3);
      cyc(1'b0, 10'd0, 1'b0, 1'b0);
`ifdef EF_DAC_SEQ_THRESH_IRQ_EN
      check("en0_irq", 32'(irq), 32'd0);
`endif

      // Async reset mid-RUN with 5 queued.
      cyc(1'b1, 10'h144, 1'b0, 1'b0);
      cyc(1'b1, 10'h155, 1'b0, 1'b0);
      cyc(1'b1, 10'h166, 1'b0, 1'b0);
      clk_div = 16'd1;
      power_up();
      cyc(1'b0, 10'd0, 1'b0, 1'b0);
      cyc(1'b0, 10'd0, 1'b0, 1'b0);
      check("pre_rst_seld", 32'(dac_seld), 32'h101);
      check("pre_rst_level", 32'(fifo_level), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_dac_en", 32'(dac_en), 32'd0);
      check("arst_dac_rst", 32'(dac_rst), 32'd1);
      check("arst_seld", 32'(dac_seld), 32'd0);
      check("arst_level", 32'(fifo_level), 32'd0);
      check("arst_running", 32'(running), 32'd0);
      step();
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
